ed25519_io_ctrl: RTL and testbench

ED25519_IO_CTRL -- requirements
Module: ed25519_io_ctrl

---
 rtl/ed25519_io_ctrl.sv | 107 ++++++++++
 tb/tb_ed25519_io_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ed25519_io_ctrl.sv
// Stream front end for an Ed25519 scalar-multiply core: gathers scalar/px/py
// from a beat stream, starts the core, then streams the result point back out.
module ed25519_io_ctrl #(
   parameter int DATA_W = 64,
   parameter int PATN_W = 256
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_in_valid,
   output logic              o_in_ready,
   input  logic [DATA_W-1:0] i_in_data,
   output logic              o_out_valid,
   input  logic              i_out_ready,
   output logic [DATA_W-1:0] o_out_data,
   output logic              o_start,
   output logic [PATN_W-1:0] o_scalar,
   output logic [PATN_W-1:0] o_px,
   output logic [PATN_W-1:0] o_py,
   input  logic              i_done,
   input  logic [PATN_W-1:0] i_rx,
   input  logic [PATN_W-1:0] i_ry
);

   localparam int NBEAT     = PATN_W / DATA_W;
   localparam int IN_BEATS  = 3 * NBEAT;
   localparam int OUT_BEATS = 2 * NBEAT;
   localparam int IN_W      = 3 * PATN_W;
   localparam int OUT_W     = 2 * PATN_W;
   localparam int CNT_W     = $clog2(IN_BEATS + 1);

   typedef enum logic [1:0] {S_RECV, S_START, S_WAIT, S_SEND} state_t;

   state_t              r_state;
   state_t              w_state_next;
   logic [IN_W-1:0]     r_in_buf;
   logic [OUT_W-1:0]    r_out_buf;
   logic [CNT_W-1:0]    r_in_cnt;
   logic [CNT_W-1:0]    r_out_cnt;
   logic                w_in_fire;
   logic                w_out_fire;
   logic                w_in_last;
   logic                w_out_last;
   logic                w_capture;

   assign w_in_fire  = o_in_ready & i_in_valid;
   assign w_out_fire = o_out_valid & i_out_ready;
   assign w_in_last  = w_in_fire & (r_in_cnt == CNT_W'(IN_BEATS - 1));
   assign w_out_last = w_out_fire & (r_out_cnt == CNT_W'(OUT_BEATS - 1));
   assign w_capture  = (r_state == S_WAIT) & i_done;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= S_RECV;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_RECV:  if (w_in_last)  w_state_next = S_START;
         S_START: w_state_next = S_WAIT;
         S_WAIT:  if (i_done)     w_state_next = S_SEND;
         S_SEND:  if (w_out_last) w_state_next = S_RECV;
         default: w_state_next = S_RECV;
      endcase
   end

   // Ready is gated by reset so nothing upstream sees a handshake mid-reset.
   always_comb begin
      o_in_ready  = (r_state == S_RECV) & i_rst_n;
      o_start     = (r_state == S_START);
      o_out_valid = (r_state == S_SEND);
      o_out_data  = o_out_valid ? r_out_buf[OUT_W-1 -: DATA_W] : '0;
   end

   // Input buffer only moves on accepted beats, which keeps the operand
   // outputs frozen until the next transaction's first beat arrives.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_in_buf <= '0;
         r_in_cnt <= '0;
      end else if (w_in_fire) begin
         r_in_buf <= {r_in_buf[IN_W-DATA_W-1:0], i_in_data};
         r_in_cnt <= w_in_last ? '0 : r_in_cnt + 1'b1;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_out_buf <= '0;
         r_out_cnt <= '0;
      end else if (w_capture) begin
         r_out_buf <= {i_rx, i_ry};
         r_out_cnt <= '0;
      end else if (w_out_fire) begin
         r_out_buf <= {r_out_buf[OUT_W-DATA_W-1:0], {DATA_W{1'b0}}};
         r_out_cnt <= w_out_last ? '0 : r_out_cnt + 1'b1;
      end
   end

   assign o_scalar = r_in_buf[IN_W-1 -: PATN_W];
   assign o_px     = r_in_buf[OUT_W-1 -: PATN_W];
   assign o_py     = r_in_buf[PATN_W-1:0];

endmodule

// File: tb/tb_ed25519_io_ctrl.sv
// Directed-plus-random bench for ed25519_io_ctrl against a queue/array model
// of the operand assembly and result streaming.
module tb_ed25519_io_ctrl;

   localparam int DW = 64;
   localparam int PW = 256;

   logic          i_clk = 1'b0;
   logic          i_rst_n = 1'b0;
   logic          i_in_valid = 1'b0;
   logic          o_in_ready;
   logic [DW-1:0] i_in_data = '0;
   logic          o_out_valid;
   logic          i_out_ready = 1'b0;
   logic [DW-1:0] o_out_data;
   logic          o_start;
   logic [PW-1:0] o_scalar, o_px, o_py;
   logic          i_done = 1'b0;
   logic [PW-1:0] i_rx = '0, i_ry = '0;

   ed25519_io_ctrl #(.DATA_W(DW), .PATN_W(PW)) dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n),
      .i_in_valid(i_in_valid), .o_in_ready(o_in_ready), .i_in_data(i_in_data),
      .o_out_valid(o_out_valid), .i_out_ready(i_out_ready), .o_out_data(o_out_data),
      .o_start(o_start), .o_scalar(o_scalar), .o_px(o_px), .o_py(o_py),
      .i_done(i_done), .i_rx(i_rx), .i_ry(i_ry)
   );

   always #5 i_clk = ~i_clk;

   int checks = 0;
   int failures = 0;

   logic [DW-1:0] in_beats [12];
   logic [PW-1:0] exp_s, exp_px, exp_py, rx, ry;
   logic [DW-1:0] out_q [$];

   task automatic check(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic timeout(input string tag);
      checks++;
      failures++;
      $error("FAIL %s observed=timeout expected=handshake", tag);
   endtask

   function automatic logic [DW-1:0] rnd64();
      return {$urandom, $urandom};
   endfunction

   // Model: operands are the beats concatenated MSW-first; the result stream
   // is rx words MSW..LSW followed by ry words MSW..LSW.
   task automatic build_model();
      exp_s  = {in_beats[0], in_beats[1], in_beats[2],  in_beats[3]};
      exp_px = {in_beats[4], in_beats[5], in_beats[6],  in_beats[7]};
      exp_py = {in_beats[8], in_beats[9], in_beats[10], in_beats[11]};
      out_q.delete();
      for (int k = 0; k < 4; k++) out_q.push_back(rx[PW-1-64*k -: 64]);
      for (int k = 0; k < 4; k++) out_q.push_back(ry[PW-1-64*k -: 64]);
   endtask

   task automatic rand_txn();
      for (int i = 0; i < 12; i++) in_beats[i] = rnd64();
      rx = {rnd64(), rnd64(), rnd64(), rnd64()};
      ry = {rnd64(), rnd64(), rnd64(), rnd64()};
      build_model();
   endtask

   task automatic send_beats(input int lo, input int hi, input int pct);
      for (int idx = lo; idx < hi; idx++) begin
         int  guard;
         bit  acc;
         guard = 0;
         acc   = 1'b0;
         while (!acc) begin
            @(negedge i_clk);
            i_in_valid = ($urandom_range(99) < pct);
            i_in_data  = i_in_valid ? in_beats[idx] : rnd64();
            if (i_in_valid) begin
               check("in_ready_recv", o_in_ready, 1);
               acc = 1'b1;
            end
            guard++;
            if (!acc && guard > 500) begin
               timeout("in_beat");
               acc = 1'b1;
            end
         end
      end
   endtask

   task automatic finish_recv();
      @(negedge i_clk);
      i_in_valid = 1'b1;
      i_in_data  = rnd64();
      check("start_pulse", o_start, 1);
      check("in_ready_start", o_in_ready, 0);
      check("scalar", o_scalar, exp_s);
      check("px", o_px, exp_px);
      check("py", o_py, exp_py);
      @(negedge i_clk);
      check("start_once", o_start, 0);
      check("in_ready_wait", o_in_ready, 0);
      repeat (2) @(negedge i_clk);
      check("out_valid_wait", o_out_valid, 0);
      check("scalar_wait", o_scalar, exp_s);
   endtask

   task automatic do_done();
      @(negedge i_clk);
      i_done = 1'b1;
      i_rx   = rx;
      i_ry   = ry;
      @(negedge i_clk);
      i_done = 1'b0;
      i_rx   = {rnd64(), rnd64(), rnd64(), rnd64()};
      i_ry   = {rnd64(), rnd64(), rnd64(), rnd64()};
      check("out_latency", o_out_valid, 1);
   endtask

   // Compares every cycle, so a beat that changes during a stall is caught.
   task automatic receive(input int n, input int pct);
      int idx;
      int guard;
      idx   = 0;
      guard = 0;
      while (idx < n) begin
         check("out_valid_send", o_out_valid, 1);
         check("out_data", o_out_data, out_q[idx]);
         check("in_ready_send", o_in_ready, 0);
         i_in_valid  = 1'b1;
         i_in_data   = rnd64();
         i_out_ready = ($urandom_range(99) < pct);
         if (i_out_ready) idx++;
         guard++;
         if (guard > 500) begin
            timeout("out_beat");
            idx = n;
         end
         if (idx < n) @(negedge i_clk);
      end
   endtask

   task automatic end_send();
      @(negedge i_clk);
      i_out_ready = 1'b0;
      i_in_valid  = 1'b0;
      check("out_valid_after", o_out_valid, 0);
      check("out_data_idle", o_out_data, 0);
      check("in_ready_after", o_in_ready, 1);
      check("scalar_hold", o_scalar, exp_s);
      check("py_hold", o_py, exp_py);
   endtask

   task automatic full_txn(input int pct);
      send_beats(0, 12, pct);
      finish_recv();
      do_done();
      receive(8, pct);
      end_send();
   endtask

   initial begin
      #1;
      check("rst_in_ready", o_in_ready, 0);
      check("rst_out_valid", o_out_valid, 0);
      check("rst_start", o_start, 0);
      check("rst_out_data", o_out_data, 0);
      check("rst_scalar", o_scalar, 0);
      @(negedge i_clk);
      i_rst_n = 1'b1;
      #1;
      check("rel_in_ready", o_in_ready, 1);

      // Counting pattern with all-ones / all-twos result, no stalls.
      for (int i = 0; i < 12; i++) in_beats[i] = 64'(i + 1);
      rx = {64{4'h1}};
      ry = {64{4'h2}};
      build_model();
      full_txn(100);

      // Same transaction under 50% valid/ready.
      full_txn(50);

      // i_done in RECV after 5 beats must be ignored.
      rand_txn();
      send_beats(0, 5, 70);
      @(negedge i_clk);
      i_in_valid = 1'b0;
      i_done     = 1'b1;
      i_rx       = {rnd64(), rnd64(), rnd64(), rnd64()};
      @(negedge i_clk);
      i_done = 1'b0;
      check("done_in_recv_ignored", o_out_valid, 0);
      check("done_in_recv_ready", o_in_ready, 1);
      send_beats(5, 12, 70);
      finish_recv();
      do_done();
      receive(8, 60);
      end_send();

      // Reset after the 3rd output beat.
      rand_txn();
      send_beats(0, 12, 80);
      finish_recv();
      do_done();
      receive(3, 100);
      @(posedge i_clk);
      #2;
      i_rst_n = 1'b0;
      #1;
      check("mid_send_rst_valid", o_out_valid, 0);
      check("mid_send_rst_data", o_out_data, 0);
      check("mid_send_rst_ready", o_in_ready, 0);
      check("mid_send_rst_scalar", o_scalar, 0);
      @(negedge i_clk);
      i_out_ready = 1'b0;
      i_in_valid  = 1'b0;
      i_rst_n     = 1'b1;
      rand_txn();
      full_txn(50);

      // Reset mid-RECV: partial operands must be discarded.
      send_beats(0, 5, 100);
      @(negedge i_clk);
      i_in_valid = 1'b0;
      i_rst_n    = 1'b0;
      #1;
      check("mid_recv_rst_px", o_px, 0);
      @(negedge i_clk);
      i_rst_n = 1'b1;
      rand_txn();
      full_txn(60);

      // Two random transactions back-to-back.
      rand_txn();
      full_txn(50);
      rand_txn();
      full_txn(50);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
